// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the SRAM burst counter.
package sram_pkg;

  localparam int OFFSET_W  = 7;
  localparam int MAX_BURST = 1 << OFFSET_W;
  localparam int LEN_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and a programmable rollover value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out
);

  // Clear wins over enable; the count returns to zero after reaching rollover_val.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_out <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_out <= {WIDTH{1'b0}};
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_out <= {WIDTH{1'b0}};
      end else begin
        count_out <= count_out + WIDTH'(1);
      end
    end else begin
      count_out <= count_out;
    end
  end

endmodule

// File: rtl/sram_burst_counter.sv
// Burst sequencer: latches a clamped burst length, issues word requests to the
// SRAM controller and tracks the word offset and acknowledged-word count.
module sram_burst_counter #(
  parameter int OFFSET_W  = sram_pkg::OFFSET_W,
  parameter int MAX_BURST = sram_pkg::MAX_BURST
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [7:0]          burst_len,
  input  logic                hold,
  input  logic                sram_ack,
  input  logic                abort,
  output logic [OFFSET_W-1:0] count_out,
  output logic                sram_req,
  output logic                busy,
  output logic                done,
  output logic [7:0]          xfer_cnt
);

  import sram_pkg::*;

  localparam logic [7:0]          MAX_LEN     = 8'(MAX_BURST);
  localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(MAX_BURST - 1);

  state_t     state;
  logic [7:0] len;
  logic [7:0] start_len;
  logic [7:0] xfer_next;
  logic       ack_ok;
  logic       last_ack;
  logic       cnt_en;
  logic       cnt_clear;

  // A zero or oversized request means a full-size burst.
  always_comb begin
    start_len = burst_len;
    if ((burst_len == 8'd0) || (burst_len > MAX_LEN)) begin
      start_len = MAX_LEN;
    end else begin
      start_len = burst_len;
    end
  end

  // Abort suppresses a same-cycle ack so it can never be counted.
  assign sram_req  = (state == RUN) && !hold;
  assign ack_ok    = sram_req && sram_ack && !abort;
  assign xfer_next = xfer_cnt + 8'd1;
  assign last_ack  = ack_ok && (xfer_next == len);
  assign cnt_en    = ack_ok && (xfer_next < len);
  assign cnt_clear = (state != RUN) || abort;

  flex_counter #(
    .WIDTH (OFFSET_W)
  ) u_offset_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (LAST_OFFSET),
    .count_out    (count_out)
  );

  // Burst FSM with registered busy/done and the transfer counter.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      len      <= 8'd0;
      xfer_cnt <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          xfer_cnt <= 8'd0;
          if (start && !abort) begin
            len   <= start_len;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            xfer_cnt <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else if (ack_ok) begin
            xfer_cnt <= xfer_next;
            if (last_ack) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              done  <= 1'b0;
            end
          end else begin
            state <= RUN;
            done  <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          xfer_cnt <= 8'd0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          xfer_cnt <= 8'd0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_counter.sv
// Scoreboard bench for sram_burst_counter: a cycle model predicts registered
// outputs, which are queued when stimulus is driven and compared after the edge.
module tb_sram_burst_counter;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic [7:0] burst_len;
  logic       hold;
  logic       sram_ack;
  logic       abort;
  logic [6:0] count_out;
  logic       sram_req;
  logic       busy;
  logic       done;
  logic [7:0] xfer_cnt;

  typedef struct {
    int cnt;
    int busy;
    int done;
    int xfer;
  } exp_t;

  exp_t sb_q[$];

  int checks;
  int errors;
  int m_state;
  int m_len;
  int m_cnt;
  int step_no;
  int last_done_step;
  int done_count;
  int peak;

  sram_burst_counter dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .burst_len (burst_len),
    .hold      (hold),
    .sram_ack  (sram_ack),
    .abort     (abort),
    .count_out (count_out),
    .sram_req  (sram_req),
    .busy      (busy),
    .done      (done),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", tag, obs, exp, step_no);
    end
  endtask

  function automatic int clamp(input int l);
    return ((l == 0) || (l > 128)) ? 128 : l;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.cnt  = (m_state == S_IDLE) ? 0 : (m_state == S_RUN) ? m_cnt : m_len - 1;
    e.busy = (m_state != S_IDLE) ? 1 : 0;
    e.done = (m_state == S_DONE) ? 1 : 0;
    e.xfer = (m_state == S_IDLE) ? 0 : m_cnt;
    return e;
  endfunction

  task automatic model_edge(input bit s, input int bl, input bit h, input bit a,
                            input bit ab, input bit r);
    if (!r) begin
      m_state = S_IDLE; m_len = 0; m_cnt = 0;
    end else if (m_state == S_IDLE) begin
      if (s && !ab) begin
        m_len = clamp(bl); m_cnt = 0; m_state = S_RUN;
      end
    end else if (m_state == S_RUN) begin
      if (ab) begin
        m_state = S_IDLE; m_cnt = 0;
      end else if (a && !h) begin
        m_cnt++;
        if (m_cnt == m_len) m_state = S_DONE;
      end
    end else begin
      m_state = S_IDLE; m_cnt = 0;
    end
  endtask

  task automatic step(input bit s, input int bl, input bit h, input bit a,
                      input bit ab, input bit r);
    exp_t e;
    start = s; burst_len = 8'(bl); hold = h; sram_ack = a; abort = ab; n_rst = r;
    #1;
    check_val("sram_req", int'(sram_req), (m_state == S_RUN && !h) ? 1 : 0);
    model_edge(s, bl, h, a, ab, r);
    sb_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    step_no++;
    e = sb_q.pop_front();
    check_val("count_out", int'(count_out), e.cnt);
    check_val("busy", int'(busy), e.busy);
    check_val("done", int'(done), e.done);
    check_val("xfer_cnt", int'(xfer_cnt), e.xfer);
    if (done) begin
      last_done_step = step_no;
      done_count++;
    end
    if (int'(count_out) > peak) peak = int'(count_out);
  endtask

  task automatic idle_steps(input int n, input bit a);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, a, 1'b0, 1'b1);
  endtask

  initial begin
    int s0;
    int d0;
    checks = 0; errors = 0; step_no = 0; last_done_step = -1; done_count = 0; peak = 0;
    m_state = S_IDLE; m_len = 0; m_cnt = 0;
    start = 1'b0; burst_len = 8'd0; hold = 1'b0; sram_ack = 1'b0; abort = 1'b0; n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step(1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_steps(2, 1'b1);

    // basic burst of 4 with an ack every cycle
    s0 = step_no;
    step(1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_steps(6, 1'b1);
    check_val("done_latency", last_done_step - s0, 5);

    // burst_len=0 clamps to 128 words; offset peaks at 127
    peak = 0; d0 = done_count;
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_steps(131, 1'b1);
    check_val("peak_offset", peak, 127);
    check_val("len0_done_pulses", done_count - d0, 1);

    // burst_len=200 also clamps to 128
    s0 = step_no;
    step(1'b1, 200, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_steps(131, 1'b1);
    check_val("len200_latency", last_done_step - s0, 129);

    // single-word burst
    step(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_steps(3, 1'b0);

    // hold with sram_ack forced high
    step(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_steps(4, 1'b1);

    // abort together with the second ack
    d0 = done_count;
    step(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_steps(4, 1'b1);
    check_val("abort_no_done", done_count - d0, 0);

    // start while busy is ignored
    s0 = step_no;
    step(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_steps(3, 1'b1);
    check_val("busy_start_done_step", last_done_step - s0, 3);

    // abort and start together in IDLE
    step(1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_steps(2, 1'b1);

    // reset for 2 cycles mid-burst
    d0 = done_count;
    step(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_steps(3, 1'b1);
    step(1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_steps(12, 1'b1);
    check_val("reset_no_done", done_count - d0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 255)) % ((i % 3 == 0) ? 256 : 9),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1);
    end

    check_val("queue_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
